// File: rtl/enc_pkg.sv
// enc_pkg: shared RV32I encoding constants for the instruction encoder and
// the decode controller. Holds the mnemonic enum, the opcode/funct3/funct7
// field values, the internal format selector and the canonical NOP word.
package enc_pkg;

  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_SUB   = 5'd1,
    MN_AND   = 5'd2,
    MN_OR    = 5'd3,
    MN_SLT   = 5'd4,
    MN_SLTU  = 5'd5,
    MN_LW    = 5'd6,
    MN_ADDI  = 5'd7,
    MN_XORI  = 5'd8,
    MN_ORI   = 5'd9,
    MN_SLTI  = 5'd10,
    MN_SLTIU = 5'd11,
    MN_JALR  = 5'd12,
    MN_SW    = 5'd13,
    MN_JAL   = 5'd14,
    MN_BEQ   = 5'd15,
    MN_BNE   = 5'd16,
    MN_BLT   = 5'd17,
    MN_BGE   = 5'd18,
    MN_LUI   = 5'd19
  } mnem_e;

  // Instruction layout families; selects immediate scatter and range rule.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4,
    FMT_U = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_enc_core.sv
// instr_enc_core: purely combinational RV32I encoder. Maps a mnemonic,
// register numbers and immediate to a 32-bit word plus an error flag.
// Macro ENC_ERR_NOP_EN: when defined, every errored request yields NOP_WORD
// instead of the truncated encoding.
module instr_enc_core
  import enc_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  fmt_e               fmt;
  logic               legalMnem;
  logic               immErr;
  logic [31:0]        rawWord;
  logic signed [31:0] immS;

  assign immS = $signed(imm_i);

  // Mnemonic lookup: format, opcode and function fields.
  always_comb begin
    opcode    = OPC_R;
    funct3    = F3_ADD;
    funct7    = F7_ZERO;
    fmt       = FMT_R;
    legalMnem = 1'b1;
    case (mnem_i)
      MN_ADD:   ;
      MN_SUB:   funct7 = F7_SUB;
      MN_AND:   funct3 = F3_AND;
      MN_OR:    funct3 = F3_OR;
      MN_SLT:   funct3 = F3_SLT;
      MN_SLTU:  funct3 = F3_SLTU;
      MN_LW:    begin fmt = FMT_I; opcode = OPC_LOAD;   funct3 = F3_SLT;  end
      MN_ADDI:  begin fmt = FMT_I; opcode = OPC_IALU;   funct3 = F3_ADD;  end
      MN_XORI:  begin fmt = FMT_I; opcode = OPC_IALU;   funct3 = F3_XOR;  end
      MN_ORI:   begin fmt = FMT_I; opcode = OPC_IALU;   funct3 = F3_OR;   end
      MN_SLTI:  begin fmt = FMT_I; opcode = OPC_IALU;   funct3 = F3_SLT;  end
      MN_SLTIU: begin fmt = FMT_I; opcode = OPC_IALU;   funct3 = F3_SLTU; end
      MN_JALR:  begin fmt = FMT_I; opcode = OPC_JALR;   funct3 = F3_ADD;  end
      MN_SW:    begin fmt = FMT_S; opcode = OPC_STORE;  funct3 = F3_SLT;  end
      MN_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;                      end
      MN_BEQ:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_ADD;  end
      MN_BNE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BNE;  end
      MN_BLT:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_XOR;  end
      MN_BGE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGE;  end
      MN_LUI:   begin fmt = FMT_U; opcode = OPC_LUI;                      end
      default:  legalMnem = 1'b0;
    endcase
  end

  // Immediate range and alignment rule for the selected format.
  always_comb begin
    immErr = 1'b0;
    case (fmt)
      FMT_I, FMT_S: immErr = (immS < -32'sd2048) || (immS > 32'sd2047);
      FMT_B:        immErr = (immS < -32'sd4096) || (immS > 32'sd4094) || imm_i[0];
      FMT_J:        immErr = (immS < -32'sd1048576) || (immS > 32'sd1048574) || imm_i[0];
      FMT_U:        immErr = (imm_i[11:0] != 12'd0);
      default:      immErr = 1'b0;
    endcase
  end

  // Field assembly; out-of-range immediates are simply truncated here.
  always_comb begin
    rawWord = 32'd0;
    case (fmt)
      FMT_R: rawWord = {funct7, rs2_i, rs1_i, funct3, rd_i, opcode};
      FMT_I: rawWord = {imm_i[11:0], rs1_i, funct3, rd_i, opcode};
      FMT_S: rawWord = {imm_i[11:5], rs2_i, rs1_i, funct3, imm_i[4:0], opcode};
      FMT_B: rawWord = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3,
                        imm_i[4:1], imm_i[11], opcode};
      FMT_J: rawWord = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode};
      FMT_U: rawWord = {imm_i[31:12], rd_i, opcode};
      default: rawWord = 32'd0;
    endcase
  end

  assign err_o = !legalMnem || immErr;

  // Final word selection for illegal or errored requests.
  always_comb begin
`ifdef ENC_ERR_NOP_EN
    word_o = err_o ? NOP_WORD : rawWord;
`else
    word_o = legalMnem ? rawWord : 32'd0;
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered valid/ready wrapper around instr_enc_core.
// Owns the single output register, the byte-address counter and the
// saturating error counter. Macro ENC_ERR_NOP_EN (passed to the core)
// replaces errored words with a NOP.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_mnem,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  logic                outValid_q, outValid_d;
  logic [31:0]         outInstr_q, outInstr_d;
  logic [ADDR_W-1:0]   outAddr_q,  outAddr_d;
  logic                outErr_q,   outErr_d;
  logic [ERRCNT_W-1:0] errCnt_q,   errCnt_d;
  logic [31:0]         coreWord;
  logic                coreErr;
  logic                accept;
  logic                handshake;

  instr_enc_core u_core (
    .mnem_i (in_mnem),
    .rd_i   (in_rd),
    .rs1_i  (in_rs1),
    .rs2_i  (in_rs2),
    .imm_i  (in_imm),
    .word_o (coreWord),
    .err_o  (coreErr)
  );

  assign in_ready  = !clear && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = outValid_q && out_ready;

  // Next state: clear wins over everything, otherwise retire then refill.
  always_comb begin
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outAddr_d  = outAddr_q;
    outErr_d   = outErr_q;
    errCnt_d   = errCnt_q;
    if (clear) begin
      outValid_d = 1'b0;
      outAddr_d  = START;
    end else begin
      if (handshake) begin
        outValid_d = 1'b0;
        outAddr_d  = outAddr_q + STEP;
        if (outErr_q && (errCnt_q != {ERRCNT_W{1'b1}})) begin
          errCnt_d = errCnt_q + 1'b1;
        end
      end
      if (accept) begin
        outValid_d = 1'b1;
        outInstr_d = coreWord;
        outErr_d   = coreErr;
      end
    end
  end

  // Output register, address counter and error counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outInstr_q <= 32'd0;
      outAddr_q  <= START;
      outErr_q   <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outAddr_q  <= outAddr_d;
      outErr_q   <= outErr_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_addr  = outAddr_q;
  assign out_err   = outErr_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the pipeline's decode controller: takes abstract instruction requests (mnemonic, registers, immediate) and emits 32-bit RV32I machine words.
- Output stream carries the word plus a sequential byte address, so the stream can load instruction memory or drive a self-checking decode bench.
- Covers exactly the decoder's instruction set: add sub and or slt sltu lw addi xori ori slti sltiu jalr sw jal beq bne blt bge lui.
- Registered valid/ready on both sides; immediate range and alignment are checked per format.

Parameters:
ADDR_W, 32, width of out_addr and of the address counter
START_ADDR, 0, out_addr value after reset or clear (must be a multiple of 4)
ERRCNT_W, 8, width of err_cnt

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous: address back to START_ADDR, pending output dropped
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_mnem  in  5  mnemonic code (enc_pkg::mnem_e)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  signed immediate / byte offset; for lui, the full upper value
out_valid  out  1  word valid
out_ready  in  1  consumer ready
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_instr
out_err  out  1  request was unencodable
err_cnt  out  ERRCNT_W  saturating count of emitted errored words

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_addr=START_ADDR, out_err=0, err_cnt=0.
- Single output register; latency 1 cycle from accept to out_valid.
- in_ready = !clear && (!out_valid || out_ready), so full throughput is one word per cycle.
- Stall: out_valid && !out_ready holds out_instr, out_addr and out_err stable.
- Output handshake (out_valid && out_ready): out_addr += 4, modulo 2^ADDR_W, wrapping silently.
  - If that word has out_err=1, err_cnt increments, saturating at all-ones.
- clear: next cycle out_valid=0 and out_addr=START_ADDR; err_cnt is kept; a simultaneous in_valid is not accepted.
- Mnemonic codes: ADD0 SUB1 AND2 OR3 SLT4 SLTU5 LW6 ADDI7 XORI8 ORI9 SLTI10 SLTIU11 JALR12 SW13 JAL14 BEQ15 BNE16 BLT17 BGE18 LUI19; codes 20-31 are illegal.
- Opcodes:
  - R 0110011
  - lw 0000011
  - I-alu 0010011
  - jalr 1100111
  - sw 0100011
  - jal 1101111
  - branch 1100011
  - lui 0110111
- funct3:
  - add/sub/addi/jalr/beq 000
  - and 111
  - or/ori 110
  - slt/slti/lw/sw 010
  - sltu/sltiu 011
  - xori/blt 100
  - bne 001
  - bge 101
- funct7: 0100000 for sub only, otherwise 0.
- Immediate legality (err=1 if violated):
  - I/S: in_imm within [-2048, 2047].
  - B: within [-4096, 4094] and bit0=0.
  - J: within [-2^20, 2^20-2] and bit0=0.
  - U: in_imm[11:0]=0.
- Fields not used by a format are ignored (e.g. rs2 for I, rd for S/B).
- Errored word: encoded from the truncated immediate fields, out_err=1.
- Illegal mnemonic: out_instr=0, out_err=1.
- Errored words still consume an address.

Optional Feature:
- Macro ENC_ERR_NOP_EN.
- When defined, any errored request emits 0x00000013 (addi x0,x0,0), still with out_err=1 and still counted.
- When undefined, the truncated encoding described above is emitted.

Decomposition:
- enc_pkg holds:
  - mnem_e enum
  - opcode, funct3 and funct7 localparams, shared with the controller
  - NOP_WORD constant
- One combinational sub-module, instr_enc_core (mnemonic/regs/imm -> word, err), stays purely combinational.
- The handshake register, address counter and error counter remain in instr_encoder.

Test Plan:
- ADD rd=3 rs1=1 rs2=2 after reset -> out_instr=0x002081B3, out_addr=0x0, err=0; 1 cycle latency.
- ADDI rd=1 rs1=0 imm=-1, then SW rs1=2 rs2=5 imm=8, back-to-back with out_ready=1 -> 0xFFF00093 @0x0, 0x00512423 @0x4; in_ready stays 1.
- BEQ rs1=1 rs2=2 imm=-4; JAL rd=1 imm=2048; LUI rd=5 imm=0x12345000 -> 0xFE208EE3, 0x001000EF, 0x123452B7.
- BEQ imm=3 and ADDI imm=4096 -> out_err=1 on both, err_cnt=2.
  - With ENC_ERR_NOP_EN defined: both words are 0x00000013.
- out_ready=0 for 5 cycles with a word pending -> outputs stable, in_ready=0; release -> word accepted, address advances by 4 exactly once.
- Mid-stream: assert clear, and separately rst_n=0 -> out_valid drops, out_addr=START_ADDR.
  - err_cnt is kept across clear and zeroed by reset.
  - With ADDR_W=4, 5 accepted words wrap out_addr 0xC -> 0x0.
